// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end sharing a single 32-bit barrel shifter.
// One operation in flight at a time: IDLE accepts, EXEC shifts, RESP holds the result.
module shift_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [4:0]       req0_shamt,
    input  logic [1:0]       req0_mode,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [4:0]       req1_shamt,
    input  logic [1:0]       req1_mode,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_data,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        last_grant;
    logic        win;
    logic        accept;
    logic [31:0] op_a;
    logic [4:0]  op_shamt;
    logic [1:0]  op_mode;
    logic        op_id;
    logic [31:0] sh_res;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0_valid || req1_valid) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        win        = req1_valid && (!req0_valid || !last_grant);
        accept     = (state == IDLE) && (req0_valid || req1_valid);
        req0_ready = accept && !win;
        req1_ready = accept && win;
        rsp_valid  = (state == RESP);
        busy       = (state != IDLE);
    end

    always_comb begin
        case (op_mode)
            2'b00:   sh_res = op_a << op_shamt;
            2'b01:   sh_res = op_a >> op_shamt;
            2'b10:   sh_res = $unsigned($signed(op_a) >>> op_shamt);
            default: sh_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
            op_count   <= '0;
            op_a       <= '0;
            op_shamt   <= '0;
            op_mode    <= '0;
            op_id      <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= win;
                op_id      <= win;
                op_a       <= win ? req1_a     : req0_a;
                op_shamt   <= win ? req1_shamt : req0_shamt;
                op_mode    <= win ? req1_mode  : req0_mode;
            end
            if (state == EXEC) begin
                rsp_data <= sh_res;
                rsp_id   <= op_id;
                rsp_err  <= (op_mode == 2'b11);
            end
            if ((state == RESP) && rsp_ready)
                op_count <= op_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Randomised plus directed bench for shift_arbiter: arbitration model and
// response scoreboard run as independent negedge monitors.
module tb_shift_arbiter;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [31:0]   req0_a = '0, req1_a = '0;
    logic [4:0]    req0_shamt = '0, req1_shamt = '0;
    logic [1:0]    req0_mode = '0, req1_mode = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic          rsp_id;
    logic [31:0]   rsp_data;
    logic          rsp_err;
    logic          busy;
    logic [CW-1:0] op_count;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        err;
        int unsigned due;
    } exp_t;

    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;
    exp_t        q[$];
    logic        dut_grants[$];
    bit          front_seen = 0;
    bit          m_busy = 0;
    bit          m_last = 1;
    int          m_cnt = 0;
    bit          done = 0;

    shift_arbiter #(.CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_shamt(req0_shamt), .req0_mode(req0_mode),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_shamt(req1_shamt), .req1_mode(req1_mode),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d required under 40000", cyc);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Shift semantics from plain integer arithmetic: SLL = multiply mod 2^32,
    // SRL = divide, SRA = floor division of the signed value.
    function automatic logic [32:0] ref_op(input logic [31:0] a, input logic [4:0] sh,
                                           input logic [1:0] m);
        longint p, v;
        p = longint'(1) << sh;
        v = longint'(a);
        case (m)
            2'd0: return {1'b0, 32'((v * p) % (longint'(1) << 32))};
            2'd1: return {1'b0, 32'(v / p)};
            2'd2: begin
                if (a[31]) v = v - (longint'(1) << 32);
                if (v < 0) v = (v - (p - 1)) / p;
                else       v = v / p;
                return {1'b0, 32'(v)};
            end
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    always @(negedge clk) begin : acc_mon
        logic        w;
        logic        go;
        logic [32:0] r;
        exp_t        e;
        if (!reset_n) begin
            m_busy = 0;
            m_last = 1;
        end else begin
            go = !m_busy && (req0_valid || req1_valid);
            w  = (req0_valid && req1_valid) ? !m_last : req1_valid;
            chk("busy", 32'(busy), 32'(m_busy));
            chk("req0_ready", 32'(req0_ready), 32'(go && !w));
            chk("req1_ready", 32'(req1_ready), 32'(go && w));
            if (req0_ready || req1_ready) dut_grants.push_back(req1_ready);
            if (go) begin
                r = w ? ref_op(req1_a, req1_shamt, req1_mode)
                      : ref_op(req0_a, req0_shamt, req0_mode);
                e.id   = w;
                e.data = r[31:0];
                e.err  = r[32];
                e.due  = cyc + 2;
                q.push_back(e);
                m_last = w;
                m_busy = 1;
            end else if (m_busy && rsp_valid && rsp_ready) begin
                m_busy = 0;
            end
        end
    end

    always @(negedge clk) begin : rsp_mon
        chk("op_count", 32'(op_count), 32'(m_cnt));
        if (rsp_valid) begin
            if (q.size() == 0) chk("rsp_valid_spurious", 32'(rsp_valid), 32'd0);
            else begin
                if (!front_seen) begin
                    chk("rsp_latency", cyc, q[0].due);
                    front_seen = 1;
                end
                chk("rsp_data", rsp_data, q[0].data);
                chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
                chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
            end
        end else if (q.size() > 0 && cyc >= q[0].due) begin
            chk("rsp_valid_missing", 32'(rsp_valid), 32'd1);
        end
        if (!reset_n) begin
            q.delete();
            front_seen = 0;
            m_cnt = 0;
        end else if (rsp_valid && rsp_ready && q.size() > 0) begin
            void'(q.pop_front());
            front_seen = 0;
            m_cnt = (m_cnt + 1) % (1 << CW);
        end
    end

    task automatic send(input bit r, input logic [31:0] a, input logic [4:0] sh,
                        input logic [1:0] m);
        if (r) begin
            req1_a = a; req1_shamt = sh; req1_mode = m; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_shamt = sh; req0_mode = m; req0_valid = 1'b1;
        end
    endtask

    task automatic wait_accept(input bit r);
        int n = 0;
        logic rdy;
        do begin
            @(negedge clk);
            n++;
            rdy = r ? req1_ready : req0_ready;
        end while (!rdy && n < 60);
        if (!rdy) chk("accept_timeout", 32'(rdy), 32'd1);
        @(posedge clk);
        #1;
        if (r) req1_valid = 1'b0;
        else   req0_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [31:0] d, output logic id, output logic err);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rsp_valid && rsp_ready) && n < 40);
        if (!(rsp_valid && rsp_ready)) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
        d = rsp_data;
        id = rsp_id;
        err = rsp_err;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || q.size() != 0) && n < 60);
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic rand_driver(input bit r, input int n);
        repeat (n) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            send(r, $urandom, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                 2'($urandom_range(0, 3)));
            wait_accept(r);
        end
    endtask

    initial begin : main
        logic [31:0] d, d0;
        logic        id, id0, err;
        logic [31:0] a;
        int          exp_cnt[5] = '{1, 2, 3, 0, 1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_op_count", 32'(op_count), 32'd0);
        chk("reset_req0_ready", 32'(req0_ready), 32'd0);
        chk("reset_req1_ready", 32'(req1_ready), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // reset during EXEC aborts; next tie goes to requester 0
        send(0, 32'h12345678, 5'd3, 2'b00);
        wait_accept(0);
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_op_count", 32'(op_count), 32'd0);
        @(posedge clk);
        #1;
        dut_grants.delete();
        send(0, 32'h0000_00F0, 5'd4, 2'b01);
        send(1, 32'h0000_000F, 5'd4, 2'b00);
        fork
            wait_accept(0);
            wait_accept(1);
        join
        chk("tie_after_reset_count", dut_grants.size(), 32'd2);
        if (dut_grants.size() > 0) chk("tie_after_reset", 32'(dut_grants[0]), 32'd0);
        wait_idle();

        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;

        // five completions with a 2-bit counter: 1,2,3,0,1
        for (int unsigned i = 0; i < 5; i++) begin
            a = $urandom;
            case (i)
                0: send(0, 32'h8000_0010, 5'd4, 2'b10);
                1: send(1, 32'hFFFF_FFFF, 5'($urandom), 2'b11);
                2, 3: send(0, a, 5'd0, 2'($urandom_range(0, 2)));
                default: send(1, a, 5'd0, 2'($urandom_range(0, 2)));
            endcase
            wait_accept((i == 1) || (i == 4));
            get_rsp(d, id, err);
            case (i)
                0: begin
                    chk("sra_data", d, 32'hF800_0001);
                    chk("sra_id", 32'(id), 32'd0);
                    chk("sra_err", 32'(err), 32'd0);
                end
                1: begin
                    chk("illegal_data", d, 32'h0);
                    chk("illegal_err", 32'(err), 32'd1);
                    chk("illegal_id", 32'(id), 32'd1);
                end
                default: chk("shamt0_data", d, a);
            endcase
            @(negedge clk);
            chk("op_count_seq", 32'(op_count), 32'(exp_cnt[i]));
            @(posedge clk);
            #1;
        end

        // continuous contention alternates grants
        dut_grants.delete();
        fork
            begin
                repeat (2) begin
                    send(0, 32'h0000_0001, 5'd31, 2'b00);
                    wait_accept(0);
                end
            end
            begin
                repeat (2) begin
                    send(1, 32'h8000_0000, 5'd31, 2'b01);
                    wait_accept(1);
                end
            end
        join
        chk("alt_grant_count", dut_grants.size(), 32'd4);
        for (int i = 0; i < 4 && i < dut_grants.size(); i++)
            chk("alt_grant", 32'(dut_grants[i]), 32'(i % 2));
        wait_idle();

        // consumer back-pressure in RESP
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        send(0, $urandom, 5'($urandom), 2'b10);
        wait_accept(0);
        send(1, $urandom, 5'($urandom), 2'b00);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!rsp_valid && n < 10);
        end
        d0 = rsp_data;
        id0 = rsp_id;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_data", rsp_data, d0);
            chk("hold_rsp_id", 32'(rsp_id), 32'(id0));
            chk("hold_busy", 32'(busy), 32'd1);
            chk("hold_req0_ready", 32'(req0_ready), 32'd0);
            chk("hold_req1_ready", 32'(req1_ready), 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_accept(1);
        wait_idle();

        // randomised traffic with random consumer stalls
        @(posedge clk);
        #1;
        fork
            begin
                fork
                    rand_driver(0, 15);
                    rand_driver(1, 15);
                join
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 rsp_ready = ($urandom_range(0, 3) != 0);
                end
                rsp_ready = 1'b1;
            end
        join
        wait_idle();
        chk("scoreboard_drained", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
